// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter that time-shares one external combinational ALU.
// Define ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FW    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FW-1:0]    req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FW-1:0]    req1_f,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_operand_a,
  output logic [WIDTH-1:0] alu_operand_b,
  output logic [FW-1:0]    alu_f,
  input  logic [WIDTH-1:0] alu_s,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [FW-1:0]    op_f_q, op_f_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;

  logic any_valid;
  logic grant;

  // grant is the index of the requester that would be accepted in IDLE
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant_q;
`endif
    end else begin
      grant = req1_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_f_d       = op_f_q;
    result_d     = result_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_data    = '0;
    rsp1_data    = '0;

    case (state_q)
      StIdle: begin
        // Ready is suppressed while reset is held so nothing appears accepted.
        if (any_valid && !i_reset) begin
          req0_ready   = ~grant;
          req1_ready   = grant;
          op_a_d       = grant ? req1_a : req0_a;
          op_b_d       = grant ? req1_b : req0_b;
          op_f_d       = grant ? req1_f : req0_f;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = StExec;
        end
      end
      StExec: begin
        result_d = alu_s;
        state_d  = StResp;
      end
      StResp: begin
        if (owner_q) begin
          rsp1_valid = 1'b1;
          rsp1_data  = result_q;
          if (rsp1_ready) state_d = StIdle;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = result_q;
          if (rsp0_ready) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= StIdle;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_f_q       <= '0;
      result_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_f_q       <= op_f_d;
      result_q     <= result_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Operands stay on the ALU after EXEC until the next accept overwrites them.
  assign alu_operand_a = op_a_q;
  assign alu_operand_b = op_b_q;
  assign alu_f         = op_f_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: transaction-level model plus directed scenarios.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
  } op_t;

  logic        clk;
  logic        i_reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_f, req1_f;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] alu_operand_a, alu_operand_b, alu_s;
  logic [3:0]  alu_f;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  op_t         q0[$];
  op_t         q1[$];
  int          gr_log[$];
  logic [31:0] got0[$];
  logic [31:0] got1[$];
  logic        hs0 = 1'b0;
  logic        hs1 = 1'b0;

  // Reference ALU standing in for the external one: RISC-V style funct3 with f[3] as alt bit.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
    case (f[2:0])
      3'd0:    return f[3] ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, ($signed(a) < $signed(b))};
      3'd3:    return {31'b0, (a < b)};
      3'd4:    return a ^ b;
      3'd5:    return f[3] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    op_t o;
    o.a = a;
    o.b = b;
    o.f = f;
    return o;
  endfunction

  assign alu_s = alu_ref(alu_operand_a, alu_operand_b, alu_f);

  alu_share_arbiter #(.WIDTH(32), .FW(4)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_f       (req0_f),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_f       (req1_f),
    .rsp0_valid   (rsp0_valid),
    .rsp0_ready   (rsp0_ready),
    .rsp0_data    (rsp0_data),
    .rsp1_valid   (rsp1_valid),
    .rsp1_ready   (rsp1_ready),
    .rsp1_data    (rsp1_data),
    .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b),
    .alu_f        (alu_f),
    .alu_s        (alu_s),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Who wins arbitration given the current valids and the last grant.
  function automatic logic winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~last;
`endif
    end
    return v1;
  endfunction

  // Model: at most one outstanding transaction; its result is known at accept time.
  logic        m_active, m_resp, m_owner, m_last;
  logic [31:0] m_a, m_b, m_result;
  logic [3:0]  m_f;

  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      m_active <= 1'b0;
      m_resp   <= 1'b0;
      m_owner  <= 1'b0;
      m_last   <= 1'b1;
      m_a      <= '0;
      m_b      <= '0;
      m_f      <= '0;
      m_result <= '0;
    end else if (!m_active) begin
      if (req0_valid || req1_valid) begin
        m_active <= 1'b1;
        m_resp   <= 1'b0;
        m_owner  <= winner(req0_valid, req1_valid, m_last);
        m_last   <= winner(req0_valid, req1_valid, m_last);
        if (winner(req0_valid, req1_valid, m_last)) begin
          m_a <= req1_a; m_b <= req1_b; m_f <= req1_f;
          m_result <= alu_ref(req1_a, req1_b, req1_f);
        end else begin
          m_a <= req0_a; m_b <= req0_b; m_f <= req0_f;
          m_result <= alu_ref(req0_a, req0_b, req0_f);
        end
      end
    end else if (!m_resp) begin
      m_resp <= 1'b1;
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_active <= 1'b0;
      m_resp   <= 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic w, e_v0, e_v1, idle_ok;
    w       = winner(req0_valid, req1_valid, m_last);
    idle_ok = !m_active && !i_reset;
    e_v0    = m_active && m_resp && !m_owner;
    e_v1    = m_active && m_resp && m_owner;
    chk("busy", 32'(busy), 32'(m_active));
    chk("req0_ready", 32'(req0_ready), 32'(idle_ok && req0_valid && !w));
    chk("req1_ready", 32'(req1_ready), 32'(idle_ok && req1_valid && w));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
    if (e_v0) chk("rsp0_data", rsp0_data, m_result);
    if (e_v1) chk("rsp1_data", rsp1_data, m_result);
    chk("alu_operand_a", alu_operand_a, m_a);
    chk("alu_operand_b", alu_operand_b, m_b);
    chk("alu_f", 32'(alu_f), 32'(m_f));
  end

  // Handshake / response monitor.
  always @(negedge clk) begin
    hs0 <= req0_valid && req0_ready;
    hs1 <= req1_valid && req1_ready;
    if (req0_valid && req0_ready) gr_log.push_back(0);
    if (req1_valid && req1_ready) gr_log.push_back(1);
    if (rsp0_valid && rsp0_ready) got0.push_back(rsp0_data);
    if (rsp1_valid && rsp1_ready) got1.push_back(rsp1_data);
  end

  // Requester drivers: present queue heads, hold until accepted.
  initial begin
    op_t t;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_f = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_f = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs0 && q0.size() > 0) t = q0.pop_front();
      if (hs1 && q1.size() > 0) t = q1.pop_front();
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin
        req0_a = q0[0].a; req0_b = q0[0].b; req0_f = q0[0].f;
      end
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin
        req1_a = q1[0].a; req1_b = q1[0].b; req1_f = q1[0].f;
      end
    end
  end

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk(nm, 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
  endtask

  initial begin
    int n;
    i_reset    = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_alu_a", alu_operand_a, 32'd0);
    @(posedge clk);
    #1 i_reset = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // 1: single ADD, latency and busy window
    @(negedge clk);
    q0.push_back(mk(32'h10, 32'h20, 4'b0000));
    @(posedge clk); #3;
    chk("t1_req0_ready_N", 32'(req0_ready), 32'd1);
    chk("t1_busy_N", 32'(busy), 32'd0);
    @(posedge clk); #3;
    chk("t1_busy_N1", 32'(busy), 32'd1);
    chk("t1_rsp0_valid_N1", 32'(rsp0_valid), 32'd0);
    @(posedge clk); #3;
    chk("t1_rsp0_valid_N2", 32'(rsp0_valid), 32'd1);
    chk("t1_rsp0_data", rsp0_data, 32'h00000030);
    @(posedge clk); #3;
    chk("t1_busy_after", 32'(busy), 32'd0);

    // 2: contention after fresh reset
    do_reset();
    gr_log.delete();
    @(negedge clk);
    q0.push_back(mk(32'h30, 32'h10, 4'b1000));
    q1.push_back(mk(32'h80000000, 32'd2, 4'b1101));
    wait_drain("t2_drain");
    chk("t2_grants", 32'(gr_log.size()), 32'd2);
    chk("t2_first", 32'(gr_log[0]), 32'd0);
    chk("t2_second", 32'(gr_log[1]), 32'd1);
    chk("t2_rsp0", got0[got0.size()-1], 32'h00000020);
    chk("t2_rsp1", got1[got1.size()-1], 32'hE0000000);
    @(negedge clk);
    q0.push_back(mk(32'h30, 32'h10, 4'b1000));
    q1.push_back(mk(32'h80000000, 32'd2, 4'b1101));
    wait_drain("t2b_drain");
    chk("t2_second_tie", 32'(gr_log[2]), 32'd0);

    // 3: backpressure on rsp1 while req0 waits
    rsp1_ready = 1'b0;
    @(negedge clk);
    q1.push_back(mk(32'd1, 32'd2, 4'b0000));
    @(negedge clk);
    q0.push_back(mk(32'h100, 32'h200, 4'b0000));
    n = 0;
    while (!rsp1_valid && n < 20) begin
      @(posedge clk); #3;
      n++;
    end
    chk("t3_rsp1_seen", 32'(n < 20), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(posedge clk); #3;
      end
      chk("t3_hold_valid", 32'(rsp1_valid), 32'd1);
      chk("t3_hold_data", rsp1_data, 32'd3);
      chk("t3_req0_blocked", 32'(req0_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp1_ready = 1'b1;
    #2 chk("t3_req0_at_hs", 32'(req0_ready), 32'd0);
    @(posedge clk); #3;
    chk("t3_req0_after_hs", 32'(req0_ready), 32'd1);
    wait_drain("t3_drain");

    // 4: reset during EXEC
    n = got0.size();
    @(negedge clk);
    q0.push_back(mk(32'hAAAAAAAA, 32'h55555555, 4'b0100));
    begin
      int k;
      k = 0;
      @(posedge clk); #3;
      while (!req0_ready && k < 10) begin
        @(posedge clk); #3;
        k++;
      end
      chk("t4_accept_seen", 32'(k < 10), 32'd1);
    end
    @(posedge clk);
    #2 i_reset = 1'b1;
    #1;
    chk("t4_busy0", 32'(busy), 32'd0);
    chk("t4_rsp0_valid0", 32'(rsp0_valid), 32'd0);
    chk("t4_alu_a0", alu_operand_a, 32'd0);
    chk("t4_alu_f0", 32'(alu_f), 32'd0);
    @(posedge clk);
    #1 i_reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #3;
      chk("t4_no_rsp", 32'(rsp0_valid), 32'd0);
    end
    chk("t4_no_xor_result", 32'(got0.size()), 32'(n));
    @(negedge clk);
    q0.push_back(mk(32'd5, 32'd6, 4'b0000));
    wait_drain("t4_drain");
    chk("t4_after_count", 32'(got0.size()), 32'(n + 1));
    chk("t4_after_data", got0[got0.size()-1], 32'd11);

    // 5: both continuously valid
    gr_log.delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(32'(i), 32'd1, 4'b0110));
      q1.push_back(mk(32'(i + 8), 32'd3, 4'b0111));
    end
    q0.push_back(mk(32'h1234, 32'd1, 4'b0000));
    q1.push_back(mk(32'h1234, 32'd2, 4'b0000));
    wait_drain("t5_drain");
    chk("t5_count", 32'(gr_log.size()), 32'd8);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) chk("t5_fixed_grant", 32'(gr_log[i]), 32'd0);
`else
    for (int i = 0; i < 4; i++) chk("t5_rr_grant", 32'(gr_log[i]), 32'((i + 1) % 2));
`endif

    // 6: idle stability
    repeat (20) begin
      @(posedge clk); #3;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_readys", 32'({req0_ready, req1_ready}), 32'd0);
      chk("t6_valids", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      chk("t6_alu_a_held", alu_operand_a, 32'h1234);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
